// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32/INT32 constants and the fp32 field struct used by ftoi and fadd.
package fpu_pkg;
    localparam int FP32_SIGN_POS = 31;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_EXP_LSB = 23;
    localparam int FP32_FRAC_W = 23;
    localparam int FP32_BIAS = 127;
    localparam logic [7:0] FTOI_SHIFT_BASE = 8'd150;
    localparam logic [31:0] INT32_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] INT32_MIN = 32'h80000000;
    typedef struct packed {
        logic sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_FRAC_W-1:0] frac;
    } fp32_t;
endpackage

// File: rtl/ftoi_if.sv
// ftoi_if: valid/ready op and result channels for ftoi; ovf only exists with FTOI_OVF_FLAG_EN.
interface ftoi_if;
    import fpu_pkg::*;
    logic in_valid;
    logic in_ready;
    fp32_t op;
    logic out_valid;
    logic out_ready;
    logic [31:0] result;
`ifdef FTOI_OVF_FLAG_EN
    logic ovf;
`endif
    modport master (
        output in_valid, op, out_ready,
        input in_ready, out_valid, result
`ifdef FTOI_OVF_FLAG_EN
        , input ovf
`endif
    );
    modport slave (
        input in_valid, op, out_ready,
        output in_ready, out_valid, result
`ifdef FTOI_OVF_FLAG_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/ftoi_align.sv
// ftoi_align: combinational FP32 unpack/align into integer magnitude plus the round bit.
module ftoi_align
    import fpu_pkg::*;
(
    input  fp32_t       op,
    output logic [31:0] magnitude,
    output logic        rbit,
    output logic        special,
    output logic        sign
);
    logic [23:0] m;
    logic [24:0] rx;
    logic [4:0] sr;
    logic [2:0] sl;
    logic lo;
    logic hi;
    assign m = {1'b1, op.frac};
    assign lo = op.exp >= FTOI_SHIFT_BASE - 8'd24 && op.exp <= FTOI_SHIFT_BASE;
    assign hi = op.exp > FTOI_SHIFT_BASE && op.exp <= FTOI_SHIFT_BASE + 8'd7;
    assign sr = 5'(FTOI_SHIFT_BASE - op.exp);
    assign sl = 3'(op.exp - FTOI_SHIFT_BASE);
    // the appended zero makes the e=150 case (no fraction left) yield rbit=0
    assign rx = {m, 1'b0} >> sr;
    assign magnitude = hi ? {8'd0, m} << sl : lo ? {8'd0, m} >> sr : '0;
    assign rbit = lo & rx[0];
    assign special = op.exp > FTOI_SHIFT_BASE + 8'd7;
    assign sign = op.sign;
endmodule

// File: rtl/ftoi.sv
// ftoi: two-stage FP32 -> INT32 converter, round half away from zero, saturating; FTOI_OVF_FLAG_EN adds ovf.
module ftoi
    import fpu_pkg::*;
(
    input logic   clk,
    input logic   reset,
    ftoi_if.slave io
);
    logic en;
    logic [31:0] a_mag;
    logic a_rbit;
    logic a_special;
    logic a_sign;
    logic s1_valid;
    logic [31:0] s1_mag;
    logic s1_rbit;
    logic s1_special;
    logic s1_sign;
    logic s1_nan;
    logic [31:0] mag_r;
    logic [31:0] res_n;
    logic out_valid_q;
    logic [31:0] result_q;
`ifdef FTOI_OVF_FLAG_EN
    logic s1_min;
    logic ovf_q;
    assign io.ovf = ovf_q;
`endif
    ftoi_align u_align (
        .op(io.op),
        .magnitude(a_mag),
        .rbit(a_rbit),
        .special(a_special),
        .sign(a_sign)
    );
    assign en = ~out_valid_q | io.out_ready;
    assign io.in_ready = en;
    assign io.out_valid = out_valid_q;
    assign io.result = result_q;
    assign mag_r = s1_mag + 32'(s1_rbit);
    assign res_n = s1_special ? ((s1_nan | ~s1_sign) ? INT32_MAX : INT32_MIN) : s1_sign ? -mag_r : mag_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            out_valid_q <= 1'b0;
            result_q <= '0;
`ifdef FTOI_OVF_FLAG_EN
            ovf_q <= 1'b0;
`endif
        end else if (en) begin
            s1_valid <= io.in_valid;
            s1_mag <= a_mag;
            s1_rbit <= a_rbit;
            s1_special <= a_special;
            s1_sign <= a_sign;
            s1_nan <= io.op.exp == 8'hFF && |io.op.frac;
            out_valid_q <= s1_valid;
            result_q <= res_n;
`ifdef FTOI_OVF_FLAG_EN
            s1_min <= io.op == 32'hCF000000;
            ovf_q <= s1_special & ~s1_min;
`endif
        end
    end
endmodule

// File: tb/tb_ftoi.sv
// tb_ftoi: directed and random checks of ftoi against an arithmetic rounding/saturation model.
module tb_ftoi;
    logic clk;
    logic reset;
    int total = 0;
    int bad = 0;
    logic [32:0] q[$];
    bit rdone;
    ftoi_if bus ();
    ftoi dut (.clk(clk), .reset(reset), .io(bus));

    typedef struct {
        logic [31:0] op;
        logic [31:0] res;
        logic ovf;
    } vec_t;
    vec_t vecs [23] = '{
        '{32'h3F800000, 32'h00000001, 1'b0}, '{32'h40200000, 32'h00000003, 1'b0},
        '{32'hC0200000, 32'hFFFFFFFD, 1'b0}, '{32'h3F000000, 32'h00000001, 1'b0},
        '{32'h3ECCCCCD, 32'h00000000, 1'b0}, '{32'h00000001, 32'h00000000, 1'b0},
        '{32'h4F32D05E, 32'h7FFFFFFF, 1'b1}, '{32'hCF000000, 32'h80000000, 1'b0},
        '{32'hFFC00000, 32'h7FFFFFFF, 1'b1}, '{32'h80000000, 32'h00000000, 1'b0},
        '{32'h4F000000, 32'h7FFFFFFF, 1'b1}, '{32'hBF000000, 32'hFFFFFFFF, 1'b0},
        '{32'h3FC00000, 32'h00000002, 1'b0}, '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0},
        '{32'h7F800000, 32'h7FFFFFFF, 1'b1}, '{32'hFF800000, 32'h80000000, 1'b1},
        '{32'hCF000001, 32'h80000000, 1'b1}, '{32'h3F7FFFFF, 32'h00000001, 1'b0},
        '{32'h3EFFFFFF, 32'h00000000, 1'b0}, '{32'h4B000001, 32'h00800001, 1'b0},
        '{32'hCB7FFFFF, 32'hFF000001, 1'b0}, '{32'h40000000, 32'h00000002, 1'b0},
        '{32'h40400000, 32'h00000003, 1'b0}
    };

    // exact value m*2^(e-150), add half an LSB and truncate, then clamp against 2^31
    function automatic logic [32:0] model(input logic [31:0] v);
        int e = int'(v[30:23]);
        longint m = longint'({1'b1, v[22:0]});
        longint mag;
        if (e == 255 && v[22:0] != 0) return {1'b1, 32'h7FFFFFFF};
        if (e == 0) mag = 0;
        else if (e >= 190) mag = longint'(1) << 40;
        else if (e >= 150) mag = m << (e - 150);
        else if (150 - e > 40) mag = 0;
        else mag = (m + (longint'(1) << (149 - e))) >> (150 - e);
        if (v[31]) begin
            if (mag > 64'h80000000) return {1'b1, 32'h80000000};
            return {1'b0, 32'd0 - mag[31:0]};
        end
        if (mag >= 64'h80000000) return {1'b1, 32'h7FFFFFFF};
        return {1'b0, mag[31:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic push_op(input logic [31:0] v);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op = v;
        @(negedge clk);
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("push_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        cycles(3);
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard: queue the model result on every accepted op, compare on every delivered result
    initial begin
        logic stall = 1'b0;
        logic [31:0] held = '0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                q.delete();
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_result", bus.result, held);
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_output got=%h want=none", bus.result);
                    end else begin
                        e = q.pop_front();
                        chk("result", bus.result, e[31:0]);
`ifdef FTOI_OVF_FLAG_EN
                        chk("ovf", 32'(bus.ovf), 32'(e[32]));
`endif
                    end
                end
                if (bus.in_valid && bus.in_ready) q.push_back(model(bus.op));
                stall = bus.out_valid && !bus.out_ready;
                held = bus.result;
            end
        end
    end

    initial begin
        logic [32:0] r;
        logic [31:0] v;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
`ifdef FTOI_OVF_FLAG_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        foreach (vecs[i]) begin
            r = model(vecs[i].op);
            chk($sformatf("model_res_%h", vecs[i].op), r[31:0], vecs[i].res);
            chk($sformatf("model_ovf_%h", vecs[i].op), 32'(r[32]), 32'(vecs[i].ovf));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        foreach (vecs[i]) push_op(vecs[i].op);
        drain();
        // back-to-back stream with the consumer stalled for three cycles
        fork
            begin
                push_op(32'h3F800000);
                push_op(32'h40000000);
                push_op(32'h40400000);
            end
            begin
                cycles(2);
                bus.out_ready = 1'b0;
                cycles(3);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        // reset with two ops in flight
        bus.out_ready = 1'b0;
        push_op(32'h3F800000);
        push_op(32'h40000000);
        cycles(1);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flush_no_stale", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    v = $urandom;
                    if (v[0]) v[30:23] = 8'($urandom_range(120, 160));
                    push_op(v);
                    cycles($urandom_range(0, 1));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
